// File: rtl/decode_stage_p_if.sv
// Fetch/decode/execute-side bus of the LC-3b decode stage: IF/ID handshake with
// instruction payload, and the ID/EX latch outputs with the execute ready.
interface decode_stage_p_if #(
  parameter int unsigned XLEN   = 16,
  parameter int unsigned CTRL_W = 32
);
  localparam int unsigned IRW  = 16;
  localparam int unsigned IDXW = 3;

  logic              if_valid;
  logic              if_ready;
  logic [IRW-1:0]    instr;
  logic [XLEN-1:0]   pc;
  logic [CTRL_W-1:0] ctrl_in;
  logic              store_sel;
  logic              link_sel;
  logic              sr1_used;
  logic              sr2_used;

  logic              ex_ready;
  logic              id_valid;
  logic [XLEN-1:0]   id_pc;
  logic [IRW-1:0]    id_ir;
  logic [CTRL_W-1:0] id_ctrl;
  logic [XLEN-1:0]   id_sr1;
  logic [XLEN-1:0]   id_sr2;
  logic [IDXW-1:0]   id_src1;
  logic [IDXW-1:0]   id_src2;
  logic [IDXW-1:0]   id_dest;

  // Environment side: fetch drives the instruction, execute drives ex_ready.
  modport master (
    output if_valid, instr, pc, ctrl_in, store_sel, link_sel, sr1_used, sr2_used,
    output ex_ready,
    input  if_ready,
    input  id_valid, id_pc, id_ir, id_ctrl, id_sr1, id_sr2, id_src1, id_src2, id_dest
  );

  modport slave (
    input  if_valid, instr, pc, ctrl_in, store_sel, link_sel, sr1_used, sr2_used,
    input  ex_ready,
    output if_ready,
    output id_valid, id_pc, id_ir, id_ctrl, id_sr1, id_sr2, id_src1, id_src2, id_dest
  );
endinterface

// File: rtl/decode_stage_p.sv
// LC-3b decode stage: register file, operand select, ID/EX latch with load-use
// interlock, flush and in-latch refresh. Define WB_BYPASS_EN for write-through.
module decode_stage_p #(
  parameter int unsigned XLEN     = 16,
  parameter int unsigned CTRL_W   = 32,
  parameter int unsigned LINK_REG = 7
) (
  input  logic                clk,
  input  logic                rst_n,
  decode_stage_p_if.slave     bus,
  input  logic                ex_valid_i,
  input  logic                ex_is_load_i,
  input  logic [2:0]          ex_dest_i,
  input  logic                wb_load_i,
  input  logic [2:0]          wb_dest_i,
  input  logic [XLEN-1:0]     wb_data_i,
  input  logic                flush_i,
  output logic                stall_o
);

  localparam int unsigned IDXW = 3;
  localparam int unsigned NREG = 8;
  localparam int unsigned IRW  = 16;

  logic [XLEN-1:0]   rf_q [NREG];

  logic              id_valid_q, id_valid_d;
  logic [XLEN-1:0]   id_pc_q,    id_pc_d;
  logic [IRW-1:0]    id_ir_q,    id_ir_d;
  logic [CTRL_W-1:0] id_ctrl_q,  id_ctrl_d;
  logic [XLEN-1:0]   id_sr1_q,   id_sr1_d;
  logic [XLEN-1:0]   id_sr2_q,   id_sr2_d;
  logic [IDXW-1:0]   id_src1_q,  id_src1_d;
  logic [IDXW-1:0]   id_src2_q,  id_src2_d;
  logic [IDXW-1:0]   id_dest_q,  id_dest_d;

  logic [IDXW-1:0]   src1_c, src2_c, dest_c;
  logic [XLEN-1:0]   opa_c, opb_c;
  logic              ld_haz_c, wb_haz_c, haz_c, stall_c, adv_c;

  // Index selection from the instruction word.
  assign src1_c = bus.instr[8:6];
  assign src2_c = bus.store_sel ? bus.instr[11:9] : bus.instr[2:0];
  assign dest_c = bus.link_sel  ? IDXW'(LINK_REG) : bus.instr[11:9];

`ifdef WB_BYPASS_EN
  // Same-cycle writeback is forwarded into the captured operand.
  assign opa_c    = (wb_load_i && (wb_dest_i == src1_c)) ? wb_data_i : rf_q[src1_c];
  assign opb_c    = (wb_load_i && (wb_dest_i == src2_c)) ? wb_data_i : rf_q[src2_c];
  assign wb_haz_c = 1'b0;
`else
  // No forwarding: wait one cycle for the array to hold the written value.
  assign opa_c    = rf_q[src1_c];
  assign opb_c    = rf_q[src2_c];
  assign wb_haz_c = wb_load_i &&
                    ((bus.sr1_used && (wb_dest_i == src1_c)) ||
                     (bus.sr2_used && (wb_dest_i == src2_c)));
`endif

  assign ld_haz_c = ex_valid_i && ex_is_load_i &&
                    ((bus.sr1_used && (ex_dest_i == src1_c)) ||
                     (bus.sr2_used && (ex_dest_i == src2_c)));
  assign haz_c    = bus.if_valid && (ld_haz_c || wb_haz_c);
  assign stall_c  = haz_c && !flush_i;
  assign adv_c    = !id_valid_q || bus.ex_ready;

  assign stall_o      = stall_c;
  assign bus.if_ready = adv_c && !stall_c;

  // Register file write port; unaffected by pipeline control.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NREG); i++) rf_q[i] <= '0;
    end else if (wb_load_i) begin
      rf_q[wb_dest_i] <= wb_data_i;
    end
  end

  // ID/EX latch next state: refresh while held, then flush > bubble > load > drain.
  always_comb begin
    id_valid_d = id_valid_q;
    id_pc_d    = id_pc_q;
    id_ir_d    = id_ir_q;
    id_ctrl_d  = id_ctrl_q;
    id_sr1_d   = id_sr1_q;
    id_sr2_d   = id_sr2_q;
    id_src1_d  = id_src1_q;
    id_src2_d  = id_src2_q;
    id_dest_d  = id_dest_q;

    if (id_valid_q && !bus.ex_ready && wb_load_i) begin
      if (wb_dest_i == id_src1_q) id_sr1_d = wb_data_i;
      if (wb_dest_i == id_src2_q) id_sr2_d = wb_data_i;
    end

    if (flush_i) begin
      id_valid_d = 1'b0;
    end else if (adv_c) begin
      if (stall_c) begin
        id_valid_d = 1'b0;
      end else if (bus.if_valid) begin
        id_valid_d = 1'b1;
        id_pc_d    = bus.pc;
        id_ir_d    = bus.instr;
        id_ctrl_d  = bus.ctrl_in;
        id_sr1_d   = opa_c;
        id_sr2_d   = opb_c;
        id_src1_d  = src1_c;
        id_src2_d  = src2_c;
        id_dest_d  = dest_c;
      end else begin
        id_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      id_valid_q <= 1'b0;
      id_pc_q    <= '0;
      id_ir_q    <= '0;
      id_ctrl_q  <= '0;
      id_sr1_q   <= '0;
      id_sr2_q   <= '0;
      id_src1_q  <= '0;
      id_src2_q  <= '0;
      id_dest_q  <= '0;
    end else begin
      id_valid_q <= id_valid_d;
      id_pc_q    <= id_pc_d;
      id_ir_q    <= id_ir_d;
      id_ctrl_q  <= id_ctrl_d;
      id_sr1_q   <= id_sr1_d;
      id_sr2_q   <= id_sr2_d;
      id_src1_q  <= id_src1_d;
      id_src2_q  <= id_src2_d;
      id_dest_q  <= id_dest_d;
    end
  end

  assign bus.id_valid = id_valid_q;
  assign bus.id_pc    = id_pc_q;
  assign bus.id_ir    = id_ir_q;
  assign bus.id_ctrl  = id_ctrl_q;
  assign bus.id_sr1   = id_sr1_q;
  assign bus.id_sr2   = id_sr2_q;
  assign bus.id_src1  = id_src1_q;
  assign bus.id_src2  = id_src2_q;
  assign bus.id_dest  = id_dest_q;

endmodule

// File: tb/tb_decode_stage_p.sv
// Directed bench for decode_stage_p: a register-file model predicts each accepted
// instruction's latch contents, compared when execute consumes the latch.
module tb_decode_stage_p;
  localparam int unsigned XLEN   = 16;
  localparam int unsigned CTRL_W = 32;

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] ir;
    logic [31:0] ctrl;
    logic [15:0] sr1;
    logic [15:0] sr2;
    logic [2:0]  s1;
    logic [2:0]  s2;
    logic [2:0]  d;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ex_valid, ex_is_load, wb_load, flush, stall;
  logic [2:0]  ex_dest, wb_dest;
  logic [15:0] wb_data;

  int errors = 0;
  int checks = 0;

  exp_t        sb [$];
  exp_t        mon_e;
  logic [15:0] model_rf [8];

  always #5 clk = ~clk;

  decode_stage_p_if #(.XLEN(XLEN), .CTRL_W(CTRL_W)) bus ();

  decode_stage_p #(.XLEN(XLEN), .CTRL_W(CTRL_W), .LINK_REG(7)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .ex_valid_i   (ex_valid),
    .ex_is_load_i (ex_is_load),
    .ex_dest_i    (ex_dest),
    .wb_load_i    (wb_load),
    .wb_dest_i    (wb_dest),
    .wb_data_i    (wb_data),
    .flush_i      (flush),
    .stall_o      (stall)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [15:0] ir, input logic [15:0] pcv,
                       input logic ss, input logic ls, input logic u1, input logic u2);
    bus.if_valid  = 1'b1;
    bus.instr     = ir;
    bus.pc        = pcv;
    bus.ctrl_in   = {16'hC0DE, ir};
    bus.store_sel = ss;
    bus.link_sel  = ls;
    bus.sr1_used  = u1;
    bus.sr2_used  = u2;
  endtask

  // Expected latch contents from the bench's own register model.
  function automatic exp_t predict();
    exp_t e;
    logic [15:0] ir;
    ir     = bus.instr;
    e.pc   = bus.pc;
    e.ir   = ir;
    e.ctrl = {16'hC0DE, ir};
    e.s1   = ir[8:6];
    e.s2   = bus.store_sel ? ir[11:9] : ir[2:0];
    e.d    = bus.link_sel ? 3'd7 : ir[11:9];
    e.sr1  = model_rf[e.s1];
    e.sr2  = model_rf[e.s2];
`ifdef WB_BYPASS_EN
    if (wb_load && wb_dest == e.s1) e.sr1 = wb_data;
    if (wb_load && wb_dest == e.s2) e.sr2 = wb_data;
`endif
    return e;
  endfunction

  // Scoreboard: push on accepted handshake, pop when execute takes the latch.
  always @(posedge clk) begin
    if (!rst_n) begin
      sb.delete();
      for (int i = 0; i < 8; i++) model_rf[i] = 16'h0;
    end else begin
      if (bus.id_valid && bus.ex_ready) begin
        chk("sb_occupancy", 32'(sb.size()), 32'd1);
        if (sb.size() > 0) begin
          mon_e = sb.pop_front();
          chk("sb_pc",   32'(bus.id_pc),   32'(mon_e.pc));
          chk("sb_ir",   32'(bus.id_ir),   32'(mon_e.ir));
          chk("sb_ctrl", bus.id_ctrl,      mon_e.ctrl);
          chk("sb_sr1",  32'(bus.id_sr1),  32'(mon_e.sr1));
          chk("sb_sr2",  32'(bus.id_sr2),  32'(mon_e.sr2));
          chk("sb_src1", 32'(bus.id_src1), 32'(mon_e.s1));
          chk("sb_src2", 32'(bus.id_src2), 32'(mon_e.s2));
          chk("sb_dest", 32'(bus.id_dest), 32'(mon_e.d));
        end
      end else if (bus.id_valid && flush) begin
        if (sb.size() > 0) mon_e = sb.pop_front();
      end else if (bus.id_valid && wb_load && sb.size() > 0) begin
        mon_e = sb[0];
        if (wb_dest == mon_e.s1) mon_e.sr1 = wb_data;
        if (wb_dest == mon_e.s2) mon_e.sr2 = wb_data;
        sb[0] = mon_e;
      end
      if (bus.if_valid && bus.if_ready && !flush) sb.push_back(predict());
      if (wb_load) model_rf[wb_dest] = wb_data;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog_timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    ex_valid = 1'b0; ex_is_load = 1'b0; ex_dest = 3'd0;
    wb_load = 1'b0; wb_dest = 3'd0; wb_data = 16'h0; flush = 1'b0;
    bus.ex_ready = 1'b1;
    bus.if_valid = 1'b0; bus.instr = 16'h0; bus.pc = 16'h0; bus.ctrl_in = 32'h0;
    bus.store_sel = 1'b0; bus.link_sel = 1'b0; bus.sr1_used = 1'b0; bus.sr2_used = 1'b0;

    // Reset held two cycles with a valid instruction presented.
    rst_n = 1'b0;
    issue(16'h1283, 16'h2000, 1'b0, 1'b0, 1'b1, 1'b1);
    cyc(); cyc();
    chk("rst_id_valid", 32'(bus.id_valid), 32'd0);
    chk("rst_id_pc",    32'(bus.id_pc),    32'd0);
    chk("rst_id_ir",    32'(bus.id_ir),    32'd0);
    chk("rst_id_ctrl",  bus.id_ctrl,       32'd0);
    chk("rst_id_sr1",   32'(bus.id_sr1),   32'd0);
    chk("rst_id_dest",  32'(bus.id_dest),  32'd0);
    rst_n = 1'b1;

    // Registers read zero after reset.
    #1 chk("post_rst_if_ready", 32'(bus.if_ready), 32'd1);
    cyc();
    chk("post_rst_valid", 32'(bus.id_valid), 32'd1);
    chk("post_rst_sr1",   32'(bus.id_sr1),   32'd0);
    chk("post_rst_sr2",   32'(bus.id_sr2),   32'd0);
    chk("post_rst_dest",  32'(bus.id_dest),  32'd1);

    // Write R3, then read it.
    bus.if_valid = 1'b0;
    wb_load = 1'b1; wb_dest = 3'd3; wb_data = 16'h1234;
    cyc();
    wb_load = 1'b0;
    issue(16'h18C0, 16'h3000, 1'b0, 1'b0, 1'b1, 1'b1);
    #1 chk("rd_stall", 32'(stall), 32'd0);
    chk("rd_if_ready", 32'(bus.if_ready), 32'd1);
    cyc();
    chk("rd_valid", 32'(bus.id_valid), 32'd1);
    chk("rd_sr1",   32'(bus.id_sr1),   32'h1234);
    chk("rd_src1",  32'(bus.id_src1),  32'd3);
    chk("rd_pc",    32'(bus.id_pc),    32'h3000);

    // Load-use interlock on src1=R2.
    ex_valid = 1'b1; ex_is_load = 1'b1; ex_dest = 3'd2;
    issue(16'h1285, 16'h3002, 1'b0, 1'b0, 1'b1, 1'b0);
    #1 chk("lu_stall", 32'(stall), 32'd1);
    chk("lu_if_ready", 32'(bus.if_ready), 32'd0);
    cyc();
    chk("lu_bubble", 32'(bus.id_valid), 32'd0);
    ex_valid = 1'b0;
    #1 chk("lu_release", 32'(stall), 32'd0);
    cyc();
    chk("lu_valid", 32'(bus.id_valid), 32'd1);
    chk("lu_pc",    32'(bus.id_pc),    32'h3002);
    chk("lu_src1",  32'(bus.id_src1),  32'd2);

    // Writeback to R5 in the same cycle as decoding src2=R5.
    issue(16'h1045, 16'h3004, 1'b0, 1'b0, 1'b1, 1'b1);
    wb_load = 1'b1; wb_dest = 3'd5; wb_data = 16'hBEEF;
    #1;
`ifdef WB_BYPASS_EN
    chk("byp_stall", 32'(stall), 32'd0);
    chk("byp_if_ready", 32'(bus.if_ready), 32'd1);
    cyc();
    wb_load = 1'b0;
`else
    chk("byp_stall", 32'(stall), 32'd1);
    chk("byp_if_ready", 32'(bus.if_ready), 32'd0);
    cyc();
    wb_load = 1'b0;
    chk("byp_bubble", 32'(bus.id_valid), 32'd0);
    #1 chk("byp_release", 32'(stall), 32'd0);
    cyc();
`endif
    chk("byp_valid", 32'(bus.id_valid), 32'd1);
    chk("byp_sr2",   32'(bus.id_sr2),   32'hBEEF);

    // Hold three cycles; refresh id_sr1 (R1) in the middle one.
    bus.ex_ready = 1'b0;
    issue(16'h5AC2, 16'h3006, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      wb_load = (i == 1); wb_dest = 3'd1; wb_data = 16'h00AA;
      #1 chk("hold_if_ready", 32'(bus.if_ready), 32'd0);
      cyc();
    end
    wb_load = 1'b0;
    chk("hold_valid", 32'(bus.id_valid), 32'd1);
    chk("hold_sr1",   32'(bus.id_sr1),   32'h00AA);
    chk("hold_sr2",   32'(bus.id_sr2),   32'hBEEF);
    chk("hold_pc",    32'(bus.id_pc),    32'h3004);
    chk("hold_ir",    32'(bus.id_ir),    32'h1045);
    bus.ex_ready = 1'b1;
    #1 chk("unhold_if_ready", 32'(bus.if_ready), 32'd1);
    cyc();
    chk("unhold_pc",  32'(bus.id_pc),  32'h3006);
    chk("unhold_sr1", 32'(bus.id_sr1), 32'h1234);

    // JSR latched, then flushed while held.
    issue(16'h4805, 16'h3008, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc();
    chk("jsr_valid", 32'(bus.id_valid), 32'd1);
    chk("jsr_dest",  32'(bus.id_dest),  32'd7);
    bus.ex_ready = 1'b0; flush = 1'b1; bus.if_valid = 1'b0;
    cyc();
    chk("flush_valid", 32'(bus.id_valid), 32'd0);
    bus.ex_ready = 1'b1;

    // Flush overrides the interlock; the accepted instruction is discarded.
    ex_valid = 1'b1; ex_is_load = 1'b1; ex_dest = 3'd2;
    issue(16'h1285, 16'h300A, 1'b0, 1'b0, 1'b1, 1'b0);
    #1 chk("flush_stall", 32'(stall), 32'd0);
    chk("flush_if_ready", 32'(bus.if_ready), 32'd1);
    cyc();
    chk("flush_discard", 32'(bus.id_valid), 32'd0);
    flush = 1'b0; ex_valid = 1'b0;

    // Unflushed JSR.
    issue(16'h4FFF, 16'h4000, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc();
    chk("jsr2_valid", 32'(bus.id_valid), 32'd1);
    chk("jsr2_dest",  32'(bus.id_dest),  32'd7);
    chk("jsr2_pc",    32'(bus.id_pc),    32'h4000);
    chk("jsr2_ctrl",  bus.id_ctrl,       32'hC0DE4FFF);

    // Reset mid-stall drops the latch and clears the register file.
    bus.ex_ready = 1'b0;
    ex_valid = 1'b1; ex_is_load = 1'b1; ex_dest = 3'd2;
    issue(16'h1285, 16'h300C, 1'b0, 1'b0, 1'b1, 1'b0);
    #1 chk("mid_stall", 32'(stall), 32'd1);
    rst_n = 1'b0;
    cyc();
    chk("mid_rst_valid", 32'(bus.id_valid), 32'd0);
    chk("mid_rst_dest",  32'(bus.id_dest),  32'd0);
    rst_n = 1'b1; ex_valid = 1'b0; bus.ex_ready = 1'b1;
    issue(16'h18C0, 16'h5000, 1'b0, 1'b0, 1'b1, 1'b1);
    cyc();
    chk("rf_cleared_sr1", 32'(bus.id_sr1), 32'd0);

    // Drain.
    bus.if_valid = 1'b0;
    cyc(); cyc();
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
